// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bus bundle for the CPU/DMA memory arbiter.
//   CPU side : cpu_address, cpu_wr_data, cpu_wr_enable -> arbiter
//              cpu_ce, cpu_rd_data                      <- arbiter
//   DMA side : dma_req, dma_address, dma_wr_data,
//              dma_wr_enable                            -> arbiter
//              dma_gnt, dma_ack, dma_rd_data            <- arbiter
//   Memory   : mem_address, mem_wr_data, mem_wr_enable  <- arbiter
//              mem_rd_data                              -> arbiter
// Modports: slave  = the arbiter itself
//           master = the environment (CPU, DMA engine and memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_wr_data;
   logic        cpu_wr_enable;
   logic        cpu_ce;
   logic [7:0]  cpu_rd_data;

   logic        dma_req;
   logic [15:0] dma_address;
   logic [7:0]  dma_wr_data;
   logic        dma_wr_enable;
   logic        dma_gnt;
   logic        dma_ack;
   logic [7:0]  dma_rd_data;

   logic [15:0] mem_address;
   logic [7:0]  mem_wr_data;
   logic        mem_wr_enable;
   logic [7:0]  mem_rd_data;

   modport slave (
      input  cpu_address, cpu_wr_data, cpu_wr_enable,
      input  dma_req, dma_address, dma_wr_data, dma_wr_enable,
      input  mem_rd_data,
      output cpu_ce, cpu_rd_data,
      output dma_gnt, dma_ack, dma_rd_data,
      output mem_address, mem_wr_data, mem_wr_enable
   );

   modport master (
      output cpu_address, cpu_wr_data, cpu_wr_enable,
      output dma_req, dma_address, dma_wr_data, dma_wr_enable,
      output mem_rd_data,
      input  cpu_ce, cpu_rd_data,
      input  dma_gnt, dma_ack, dma_rd_data,
      input  mem_address, mem_wr_data, mem_wr_enable
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between a CPU (which can be
// frozen through cpu_ce) and a DMA engine that transfers bursts of beats.
// The CPU owns the bus by default; a DMA request takes the bus for up to
// MAX_BURST beats, then a RELEASE cycle re-presents the CPU address so the
// CPU sees correct read data the moment it is un-frozen.
//
// Ports:
//   clk     - rising-edge clock
//   resetn  - synchronous, active-low reset
//   bus     - mem_arbiter_if.slave (CPU, DMA and memory signals)
// Parameters:
//   MAX_BURST - max consecutive DMA beats per grant (1..255)
// Build option:
//   ARB_DMA_WR_EN - when defined, DMA beats may write memory; otherwise DMA
//                   beats are read-only and dma_wr_enable is ignored.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           resetn,
   mem_arbiter_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   // Counter value when the beat being accepted is beat number MAX_BURST.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

   typedef enum logic [2:0] {
      CPU_OWN  = 3'b001,
      DMA_XFER = 3'b010,
      RELEASE  = 3'b100
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] burst_cnt;
   logic             cpu_ce_q;
   logic             dma_gnt_q;
   logic             dma_ack_q;
   logic             dma_wr_gated;

`ifdef ARB_DMA_WR_EN
   assign dma_wr_gated = bus.dma_wr_enable & bus.dma_req;
`else
   logic dma_wr_unused;
   assign dma_wr_unused = bus.dma_wr_enable;
   assign dma_wr_gated  = 1'b0;
`endif

   // Ownership FSM; cpu_ce / dma_gnt are registered together with the state
   // so they are glitch-free decodes of the state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= CPU_OWN;
         burst_cnt <= '0;
         cpu_ce_q  <= 1'b1;
         dma_gnt_q <= 1'b0;
         dma_ack_q <= 1'b0;
      end else begin
         dma_ack_q <= (state == DMA_XFER) && bus.dma_req;
         case (state)
            CPU_OWN: begin
               burst_cnt <= '0;
               if (bus.dma_req) begin
                  state     <= DMA_XFER;
                  cpu_ce_q  <= 1'b0;
                  dma_gnt_q <= 1'b1;
               end
            end
            DMA_XFER: begin
               if (bus.dma_req) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
               end
               if (!bus.dma_req || (burst_cnt == LAST_CNT)) begin
                  state     <= RELEASE;
                  dma_gnt_q <= 1'b0;
               end
            end
            RELEASE: begin
               // dma_req deliberately ignored: the CPU always gets a cycle.
               state     <= CPU_OWN;
               burst_cnt <= '0;
               cpu_ce_q  <= 1'b1;
               dma_gnt_q <= 1'b0;
            end
            default: begin
               state     <= CPU_OWN;
               burst_cnt <= '0;
               cpu_ce_q  <= 1'b1;
               dma_gnt_q <= 1'b0;
            end
         endcase
      end
   end

   // Memory port steering.
   always_comb begin
      bus.mem_address   = bus.cpu_address;
      bus.mem_wr_data   = bus.cpu_wr_data;
      bus.mem_wr_enable = 1'b0;
      case (state)
         CPU_OWN: begin
            bus.mem_wr_enable = bus.cpu_wr_enable;
         end
         DMA_XFER: begin
            bus.mem_address   = bus.dma_address;
            bus.mem_wr_data   = bus.dma_wr_data;
            bus.mem_wr_enable = dma_wr_gated;
         end
         RELEASE: begin
            // Re-issue the CPU address with writes blocked; the frozen CPU's
            // strobe must not reach memory.
            bus.mem_wr_enable = 1'b0;
         end
         default: begin
            bus.mem_wr_enable = 1'b0;
         end
      endcase
   end

   assign bus.cpu_ce      = cpu_ce_q;
   assign bus.dma_gnt     = dma_gnt_q;
   assign bus.dma_ack     = dma_ack_q;
   assign bus.cpu_rd_data = bus.mem_rd_data;
   // Memory read data lags the address by one cycle, which is exactly the ack.
   assign bus.dma_rd_data = dma_ack_q ? bus.mem_rd_data : 8'h00;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum number of consecutive DMA beats before the arbiter returns the bus to the CPU; legal range 1..255.
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 resetn  input  1  reset; synchronous, active-low.
REQ-004 cpu_address  input  16  processor bus address.
REQ-005 cpu_wr_data  input  8  processor write data.
REQ-006 cpu_wr_enable  input  1  processor write strobe.
REQ-007 cpu_ce  output  1  processor clock enable; the processor freezes all state while low.
REQ-008 cpu_rd_data  output  8  read data to the processor.
REQ-009 dma_req  input  1  DMA request; held high while beats are pending.
REQ-010 dma_address  input  16  DMA beat address.
REQ-011 dma_wr_data  input  8  DMA write data.
REQ-012 dma_wr_enable  input  1  DMA write strobe.
REQ-013 dma_gnt  output  1  DMA owns the bus this cycle; a beat is accepted when dma_req and dma_gnt are both high.
REQ-014 dma_ack  output  1  registered; marks the completion of the beat accepted in the previous cycle.
REQ-015 dma_rd_data  output  8  read data for the acknowledged beat; valid only while dma_ack is high.
REQ-016 mem_address, mem_wr_data, mem_wr_enable  output  16/8/1  single-port synchronous memory port.
REQ-017 mem_rd_data  input  8  memory read data, valid one cycle after the address is presented.

Function
REQ-018 The FSM SHALL have three states, CPU_OWN, DMA_XFER and RELEASE, and be one-hot encoded.
REQ-019 CPU_OWN: mem port = cpu signals, cpu_ce=1, dma_gnt=0, cpu_rd_data=mem_rd_data.
REQ-020 CPU_OWN with dma_req=1 SHALL go to DMA_XFER next cycle; the CPU access in that cycle completes normally.
REQ-021 DMA_XFER: mem port = dma signals, cpu_ce=0, dma_gnt=1, mem_wr_enable=dma_wr_enable & dma_req.
REQ-022 The burst counter SHALL clear on entry to DMA_XFER and increment on each accepted beat; its width is sufficient to hold MAX_BURST.
REQ-023 DMA_XFER SHALL go to RELEASE when dma_req=0, or when the beat being accepted is beat number MAX_BURST.
REQ-024 dma_ack SHALL equal (DMA_XFER & dma_req) registered one cycle, with dma_rd_data driven from mem_rd_data in that cycle; a beat accepted in the last DMA_XFER cycle still receives its ack during RELEASE.
REQ-025 RELEASE: mem_address=cpu_address, mem_wr_enable=0, cpu_ce=0, dma_gnt=0; next state is CPU_OWN unconditionally. This re-issues the CPU address so that mem_rd_data matches cpu_address when cpu_ce returns.
REQ-026 After RELEASE the CPU SHALL receive at least one CPU_OWN cycle before any re-grant; dma_req is ignored while in RELEASE.
REQ-027 cpu_wr_enable SHALL never reach mem_wr_enable while cpu_ce=0.
REQ-028 MAX_BURST=1 SHALL yield the pattern DMA_XFER, RELEASE, CPU_OWN per beat under continuous dma_req.

Reset
REQ-029 While resetn=0 at a clock edge: state=CPU_OWN, burst counter=0, dma_ack=0, dma_rd_data=8'h00.
REQ-030 Combinational outputs follow CPU_OWN after reset: cpu_ce=1, dma_gnt=0, mem port = cpu signals.
REQ-031 Reset mid-burst SHALL abandon the burst; no dma_ack is issued for a beat accepted in the cycle reset is applied.

Configuration
REQ-032 Macro ARB_DMA_WR_EN defined: DMA writes are supported as in REQ-021.
REQ-033 Macro ARB_DMA_WR_EN undefined: dma_wr_enable is ignored, mem_wr_enable=0 in DMA_XFER, and DMA beats are read-only; all other timing is unchanged.

Verification
REQ-034 Idle DMA, CPU reads 16'h1234 holding 8'hA5 -> cpu_ce stays 1; cpu_rd_data=8'hA5 one cycle later.
REQ-035 dma_req held high for 6 beats, MAX_BURST=4, at addresses 16'h0200..0205 -> 4 gnt cycles, RELEASE, 1 CPU_OWN cycle, then 2 gnt cycles; 6 acks total with matching data.
REQ-036 CPU address 16'h8000 frozen across a burst -> RELEASE drives mem_address=16'h8000; the first cpu_ce=1 cycle delivers mem[16'h8000].
REQ-037 DMA write 8'h3C to 16'h0010 -> memory updated with ARB_DMA_WR_EN defined; memory unchanged without it.
REQ-038 resetn pulled low in the 2nd beat of a burst -> next cycle state=CPU_OWN, cpu_ce=1, dma_ack=0.
REQ-039 dma_req dropped after 1 beat -> RELEASE next cycle; cpu_wr_enable=1 during RELEASE produces no memory write.
